// File: rtl/online_to_binary_converter_if.sv
// Digit-stream and result bundle between the on-line adder side (master)
// and the on-the-fly converter (slave).
interface online_to_binary_converter_if #(
  parameter int N = 8
) ();
  logic         start;
  logic         digit_valid;
  logic [1:0]   digit_in;
  logic [N:0]   result;
  logic         done;
  logic         busy;

  modport master (
    output start, digit_valid, digit_in,
    input  result, done, busy
  );

  modport slave (
    input  start, digit_valid, digit_in,
    output result, done, busy
  );
endinterface

// File: rtl/online_to_binary_converter.sv
// On-the-fly conversion of an MSD-first radix-2 signed-digit stream into an
// (N+1)-bit two's-complement word using Q/QM registers, no carry chain.
module online_to_binary_converter #(
  parameter int N = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  online_to_binary_converter_if.slave   bus
);
  localparam int W  = N + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    q_reg, q_next;
  logic [W-1:0]    qm_reg, qm_next;
  logic [W-1:0]    result_reg, result_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            done_reg, done_next;

  logic [W-1:0]    q_base, qm_base;
  logic [CW-1:0]   cnt_base;
  logic            accept, last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      q_reg      <= '0;
      qm_reg     <= '1;
      cnt_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      q_reg      <= q_next;
      qm_reg     <= qm_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    q_next      = q_reg;
    qm_next     = qm_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    done_next   = 1'b0;

    // A start re-seeds Q/QM/cnt so a same-cycle digit is taken as digit 0.
    q_base   = bus.start ? '0 : q_reg;
    qm_base  = bus.start ? '1 : qm_reg;
    cnt_base = bus.start ? '0 : cnt_reg;

    accept = bus.digit_valid && (bus.start || (state_reg == CONV));
    last   = accept && (cnt_base == CW'(N - 1));

    if (bus.start) begin
      state_next = CONV;
      q_next     = q_base;
      qm_next    = qm_base;
      cnt_next   = cnt_base;
    end

    if (accept) begin
      case (bus.digit_in)
        2'b10: begin
          q_next  = {q_base[W-2:0], 1'b1};
          qm_next = {q_base[W-2:0], 1'b0};
        end
        2'b01: begin
          q_next  = {qm_base[W-2:0], 1'b1};
          qm_next = {qm_base[W-2:0], 1'b0};
        end
        default: begin
          q_next  = {q_base[W-2:0], 1'b0};
          qm_next = {qm_base[W-2:0], 1'b1};
        end
      endcase
      cnt_next = cnt_base + CW'(1);
    end

    if (last) begin
      state_next  = IDLE;
      result_next = q_next;
      done_next   = 1'b1;
      cnt_next    = '0;
    end
  end

  always_comb begin
    bus.busy   = (state_reg == CONV);
    bus.result = result_reg;
    bus.done   = done_reg;
  end
endmodule

// File: tb/tb_online_to_binary_converter.sv
// Self-checking bench: fixed vectors, multi-cycle corner sequences and random
// words compared against an arithmetic digit-weight model.
module tb_online_to_binary_converter;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  online_to_binary_converter_if #(.N(N)) bus ();

  online_to_binary_converter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] codes;
    logic [8:0]  exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int done_cycle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Value of the word = sum of digit * 2^(N-1-k), digit 0 received first.
  function automatic logic [8:0] ref_value(input logic [15:0] codes);
    int acc = 0;
    for (int k = 0; k < N; k++) begin
      logic [1:0] c;
      c = codes[15-2*k -: 2];
      if (c == 2'b10) acc += (1 << (N - 1 - k));
      else if (c == 2'b01) acc -= (1 << (N - 1 - k));
    end
    return 9'(acc);
  endfunction

  task automatic send_word(input logic [15:0] codes, input int gaps[8], input logic [8:0] exp);
    logic [8:0] held;
    for (int k = 0; k < N; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        bus.start       = 1'b0;
        bus.digit_valid = (k == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.digit_in    = 2'($urandom);
        held = bus.result;
        tick();
        check("gap_done", 32'(bus.done), 32'(0));
        check("gap_result", 32'(bus.result), 32'(held));
      end
      bus.start       = (k == 0);
      bus.digit_valid = 1'b1;
      bus.digit_in    = codes[15-2*k -: 2];
      tick();
      if (k < N - 1) begin
        check("mid_done", 32'(bus.done), 32'(0));
        check("mid_busy", 32'(bus.busy), 32'(1));
      end else begin
        check("final_done", 32'(bus.done), 32'(1));
        check("final_result", 32'(bus.result), 32'(exp));
        check("final_busy", 32'(bus.busy), 32'(0));
        done_cycle = cycle;
      end
    end
    bus.start       = 1'b0;
    bus.digit_valid = 1'b0;
  endtask

  task automatic idle_tick;
    logic [8:0] held;
    bus.start       = 1'b0;
    bus.digit_valid = 1'b0;
    held = bus.result;
    tick();
    check("idle_done", 32'(bus.done), 32'(0));
    check("idle_result", 32'(bus.result), 32'(held));
  endtask

  initial begin
    vec_t tbl[6];
    int   zg[8];
    int   gg[8];
    int   c1;
    logic [8:0]  held;
    logic [15:0] rc;

    tbl[0] = '{16'h8605, 9'h06D};
    tbl[1] = '{16'hAAAA, 9'h0FF};
    tbl[2] = '{16'h5555, 9'h101};
    tbl[3] = '{16'h4000, 9'h180};
    tbl[4] = '{16'h3C0F, 9'h000};
    tbl[5] = '{16'h0002, 9'h001};
    zg = '{default: 0};
    gg = '{0, 0, 1, 3, 0, 1, 3, 0};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit_in = 2'b00;
    tick();
    tick();
    check("reset_result", 32'(bus.result), 32'(0));
    check("reset_done", 32'(bus.done), 32'(0));
    check("reset_busy", 32'(bus.busy), 32'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send_word(tbl[i].codes, zg, tbl[i].exp);
      idle_tick();
    end

    // Gaps between valid digits.
    send_word(16'h9000, gg, 9'h040);
    idle_tick();

    // Reset mid-conversion discards the partial word.
    for (int k = 0; k < 4; k++) begin
      bus.start = (k == 0);
      bus.digit_valid = 1'b1;
      bus.digit_in = 2'b10;
      tick();
      check("pre_abort_done", 32'(bus.done), 32'(0));
    end
    rst_n = 1'b0;
    bus.start = 1'b0;
    tick();
    check("abort_done", 32'(bus.done), 32'(0));
    check("abort_result", 32'(bus.result), 32'(0));
    check("abort_busy", 32'(bus.busy), 32'(0));
    rst_n = 1'b1;
    idle_tick();
    check("post_abort_result", 32'(bus.result), 32'(0));
    send_word(16'hAAAA, zg, 9'h0FF);
    idle_tick();

    // Restart after five digits; only the new word completes.
    for (int k = 0; k < 5; k++) begin
      bus.start = (k == 0);
      bus.digit_valid = 1'b1;
      bus.digit_in = 2'b01;
      tick();
      check("pre_restart_done", 32'(bus.done), 32'(0));
    end
    send_word(16'h0002, zg, 9'h001);
    idle_tick();

    // Valid digits in IDLE without start are ignored.
    held = bus.result;
    for (int k = 0; k < 4; k++) begin
      bus.start = 1'b0;
      bus.digit_valid = 1'b1;
      bus.digit_in = 2'($urandom);
      tick();
      check("idle_valid_busy", 32'(bus.busy), 32'(0));
      check("idle_valid_done", 32'(bus.done), 32'(0));
      check("idle_valid_result", 32'(bus.result), 32'(held));
    end
    bus.digit_valid = 1'b0;

    // Back-to-back words, second start in the done cycle.
    send_word(16'h8605, zg, 9'h06D);
    c1 = done_cycle;
    send_word(16'h5555, zg, 9'h101);
    check("b2b_spacing", 32'(done_cycle - c1), 32'(8));
    idle_tick();

    // Random words with random gaps against the digit-weight model.
    for (int w = 0; w < 30; w++) begin
      rc = 16'($urandom);
      for (int k = 0; k < 8; k++) gg[k] = $urandom_range(0, 2);
      if (w % 3 == 0) gg[0] = 0;
      send_word(rc, gg, ref_value(rc));
      if (w % 4 == 0) idle_tick();
    end
    idle_tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
